// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: sub-word stores/loads, alignment faults, registered read and a post-reset clear engine.
// Optional per-byte even parity with a par_err strobe is enabled by defining DMEM_PARITY_EN.
module dmem_bytelane #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wd,
    output logic [WIDTH-1:0]  rd,
    output logic              rd_valid,
    output logic              fault,
`ifdef DMEM_PARITY_EN
    output logic              par_err,
`endif
    output logic              busy
);

    localparam int NB     = WIDTH / 8;
    localparam int LB     = $clog2(NB);
    localparam int IDX_W  = ADDR_W - LB;
    localparam int NWORDS = 1 << IDX_W;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [IDX_W-1:0]   r_clrCnt;
    logic [WIDTH-1:0]   r_mem [NWORDS];
    logic [WIDTH-1:0]   r_rd;
    logic               r_rdValid;
    logic               r_fault;

    logic [LB-1:0]      w_lane;
    logic [IDX_W-1:0]   w_idx;
    logic [LB+2:0]      w_shamt;
    logic               w_req;
    logic               w_reject;
    logic               w_misaligned;
    logic               w_badSize;
    logic               w_doLoad;
    logic               w_doStore;
    logic [7:0]         w_sizeMask;
    logic [NB-1:0]      w_mask;
    logic [WIDTH-1:0]   w_wdata;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_fieldMask;
    logic               w_signBit;
    logic [WIDTH-1:0]   w_loadData;

    assign w_lane    = addr[LB-1:0];
    assign w_idx     = addr[ADDR_W-1:LB];
    assign w_shamt   = {w_lane, 3'b000};
    assign w_wdata   = wd << w_shamt;
    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> w_shamt;

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        case (r_state)
            S_CLEAR: begin
                busy = 1'b1;
                if (&r_clrCnt) w_nextState = S_READY;
            end
            S_READY: w_nextState = S_READY;
            default: w_nextState = S_CLEAR;
        endcase
    end

    // Size decode: lane mask, alignment, and the field mask/sign bit used for extension.
    always_comb begin
        w_sizeMask   = 8'h01;
        w_misaligned = 1'b0;
        w_badSize    = 1'b0;
        w_fieldMask  = '1;
        w_signBit    = 1'b0;
        case (size)
            2'b00: begin
                w_sizeMask  = 8'h01;
                w_fieldMask = WIDTH'(8'hFF);
                w_signBit   = w_shifted[7];
            end
            2'b01: begin
                w_sizeMask   = 8'h03;
                w_misaligned = addr[0];
                w_fieldMask  = WIDTH'(16'hFFFF);
                w_signBit    = w_shifted[15];
            end
            2'b10: begin
                w_sizeMask   = 8'h0F;
                w_misaligned = (addr[1:0] != 2'b00);
                w_fieldMask  = WIDTH'(32'hFFFF_FFFF);
                w_signBit    = w_shifted[31];
            end
            default: begin
                w_sizeMask   = 8'hFF;
                w_badSize    = (WIDTH != 64);
                w_misaligned = (addr[2:0] != 3'b000);
            end
        endcase
    end

    assign w_mask     = w_sizeMask[NB-1:0] << w_lane;
    assign w_loadData = (w_shifted & w_fieldMask)
                      | ({WIDTH{w_signBit & ~ld_unsigned}} & ~w_fieldMask);

    assign w_req     = (r_state == S_READY) && (mem_read || mem_write);
    assign w_reject  = (mem_read && mem_write) || w_badSize || w_misaligned;
    assign w_doLoad  = w_req && mem_read && !w_reject;
    assign w_doStore = w_req && mem_write && !w_reject;

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] r_par [NWORDS];
    logic [NB-1:0] w_calcPar;
    logic          r_parErr;

    always_comb begin
        w_calcPar = '0;
        for (int k = 0; k < NB; k++) w_calcPar[k] = ^w_word[8*k +: 8];
    end
`endif

    // Array has no reset; writes are gated by rst so nothing lands while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clrCnt] <= '0;
`ifdef DMEM_PARITY_EN
                r_par[r_clrCnt] <= '0;
`endif
            end else if (w_doStore) begin
                for (int k = 0; k < NB; k++) begin
                    if (w_mask[k]) begin
                        r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
`ifdef DMEM_PARITY_EN
                        r_par[w_idx][k] <= ^w_wdata[8*k +: 8];
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_CLEAR;
            r_clrCnt  <= '0;
            r_rd      <= '0;
            r_rdValid <= 1'b0;
            r_fault   <= 1'b0;
`ifdef DMEM_PARITY_EN
            r_parErr  <= 1'b0;
`endif
        end else begin
            r_state   <= w_nextState;
            if (r_state == S_CLEAR) r_clrCnt <= r_clrCnt + IDX_W'(1);
            r_rdValid <= w_doLoad;
            r_fault   <= w_req && w_reject;
            if (w_doLoad) r_rd <= w_loadData;
`ifdef DMEM_PARITY_EN
            r_parErr  <= w_doLoad && (|(w_mask & (w_calcPar ^ r_par[w_idx])));
`endif
        end
    end

    assign rd       = r_rd;
    assign rd_valid = r_rdValid;
    assign fault    = r_fault;
`ifdef DMEM_PARITY_EN
    assign par_err  = r_parErr;
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane (WIDTH=32, ADDR_W=12): expectations queued at issue, checked by a monitor.
module tb_dmem_bytelane;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              ld_unsigned = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [WIDTH-1:0]  wd = '0;
    logic [WIDTH-1:0]  rd;
    logic              rd_valid;
    logic              fault;
    logic              busy;
`ifdef DMEM_PARITY_EN
    logic              par_err;
`endif

    typedef struct {
        bit          isFault;
        logic [31:0] rdv;
        bit          par;
    } exp_t;

    exp_t        expQ[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] lastRd = '0;
    int          run = 0;
    int          maxRun = 0;

    dmem_bytelane #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wd          (wd),
        .rd          (rd),
        .rd_valid    (rd_valid),
        .fault       (fault),
`ifdef DMEM_PARITY_EN
        .par_err     (par_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One request held across one sampling posedge, then the bus returns to idle.
    task automatic applyStimulus(input bit rq, input bit wq, input logic [1:0] sz, input bit uns,
                                 input logic [11:0] a, input logic [31:0] d);
        mem_read    = rq;
        mem_write   = wq;
        size        = sz;
        ld_unsigned = uns;
        addr        = a;
        wd          = d;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic loadOp(input logic [1:0] sz, input bit uns, input logic [11:0] a,
                          input logic [31:0] expv, input bit expPar);
        expQ.push_back('{isFault: 1'b0, rdv: expv, par: expPar});
        lastRd = expv;
        applyStimulus(1'b1, 1'b0, sz, uns, a, 32'h0);
    endtask

    task automatic storeOp(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, sz, 1'b0, a, d);
    endtask

    task automatic faultOp(input bit rq, input bit wq, input logic [1:0] sz, input logic [11:0] a,
                           input logic [31:0] d);
        expQ.push_back('{isFault: 1'b1, rdv: lastRd, par: 1'b0});
        applyStimulus(rq, wq, sz, 1'b0, a, d);
    endtask

    task automatic countBusy(input string name);
        int cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        checkOutput(name, cnt, 1024);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_valid) run++;
        else run = 0;
        if (run > maxRun) maxRun = run;
        if (rd_valid || fault) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_strobe: rd_valid=%0b fault=%0b with no request pending", rd_valid, fault);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("rd_valid", {31'b0, rd_valid}, {31'b0, !e.isFault});
                checkOutput("fault", {31'b0, fault}, {31'b0, e.isFault});
                checkOutput("rd", rd, e.rdv);
`ifdef DMEM_PARITY_EN
                checkOutput("par_err", {31'b0, par_err}, {31'b0, e.par});
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_rd", rd, 32'h0);
        checkOutput("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
        checkOutput("reset_fault", {31'b0, fault}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        countBusy("clear_cycles");
        @(posedge clk);
        #1;
        loadOp(2'b10, 1'b0, 12'h3FC, 32'h0000_0000, 1'b0);

        storeOp(2'b10, 12'h010, 32'h80FF_7F01);
        storeOp(2'b00, 12'h012, 32'h0000_00AA);
        loadOp(2'b10, 1'b0, 12'h010, 32'h80AA_7F01, 1'b0);
        loadOp(2'b00, 1'b0, 12'h012, 32'hFFFF_FFAA, 1'b0);
        loadOp(2'b00, 1'b1, 12'h012, 32'h0000_00AA, 1'b0);
        loadOp(2'b01, 1'b0, 12'h012, 32'hFFFF_80AA, 1'b0);
        loadOp(2'b01, 1'b1, 12'h010, 32'h0000_7F01, 1'b0);

        faultOp(1'b1, 1'b0, 2'b01, 12'h011, 32'h0);
        faultOp(1'b0, 1'b1, 2'b10, 12'h022, 32'h1122_3344);
        loadOp(2'b10, 1'b0, 12'h020, 32'h0000_0000, 1'b0);
        faultOp(1'b1, 1'b0, 2'b11, 12'h030, 32'h0);
        faultOp(1'b1, 1'b1, 2'b10, 12'h010, 32'h1234_5678);
        loadOp(2'b10, 1'b0, 12'h010, 32'h80AA_7F01, 1'b0);

        storeOp(2'b10, 12'h100, 32'hDEAD_BEEF);
        loadOp(2'b10, 1'b0, 12'h100, 32'hDEAD_BEEF, 1'b0);
        repeat (2) @(posedge clk);
        #1 maxRun = 0;
        loadOp(2'b10, 1'b0, 12'h100, 32'hDEAD_BEEF, 1'b0);
        loadOp(2'b00, 1'b0, 12'h101, 32'hFFFF_FFBE, 1'b0);
        loadOp(2'b01, 1'b1, 12'h102, 32'h0000_DEAD, 1'b0);
        loadOp(2'b00, 1'b1, 12'h103, 32'h0000_00DE, 1'b0);
        repeat (2) @(posedge clk);
        #1 checkOutput("b2b_valid_run", maxRun, 4);

`ifdef DMEM_PARITY_EN
        storeOp(2'b10, 12'h040, 32'h1234_5678);
        dut.r_mem[16][0] = ~dut.r_mem[16][0];
        loadOp(2'b00, 1'b1, 12'h040, 32'h0000_0079, 1'b1);
        loadOp(2'b00, 1'b1, 12'h041, 32'h0000_0056, 1'b0);
`endif

        // Restart clear, issue requests while busy, then reset again halfway through.
        @(posedge clk);
        #1 rst = 1'b0;
        lastRd = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 12'h100, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 12'h011, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 12'h200, 32'hCAFE_F00D);
        repeat (396) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midclear_reset_busy", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        countBusy("clear_cycles_restart");
        @(posedge clk);
        #1;
        loadOp(2'b10, 1'b0, 12'h010, 32'h0000_0000, 1'b0);
        loadOp(2'b10, 1'b0, 12'h200, 32'h0000_0000, 1'b0);

        repeat (3) @(posedge clk);
        #1 checkOutput("pending_expectations", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
